// File: rtl/mips_pkg.sv
// Shared MIPS definitions: HI/LO unit op encodings and multiply/divide FSM states.
package mips_pkg;

    typedef enum logic [1:0] {
        OpMult  = 2'b00,
        OpMultu = 2'b01,
        OpDiv   = 2'b10,
        OpDivu  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFix  = 2'b10
    } md_state_e;

    function automatic logic md_is_signed(input md_op_e o);
        return (o == OpMult) || (o == OpDiv);
    endfunction

    function automatic logic md_is_div(input md_op_e o);
        return (o == OpDiv) || (o == OpDivu);
    endfunction

endpackage

// File: rtl/exe_muldiv.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// One shift-add or restoring-subtract step per cycle on operand magnitudes, sign fix at the end.
module exe_muldiv
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;    // product high half / partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;    // multiplier-and-product low half / dividend-and-quotient
    logic [WIDTH:0]   mag_b_q, mag_b_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    // Launch-time operand conditioning
    md_op_e           op_in;
    logic             sgn_in, a_neg, b_neg;
    logic [WIDTH:0]   mag_a, mag_b;

    assign op_in  = md_op_e'(op);
    assign sgn_in = md_is_signed(op_in);
    assign a_neg  = sgn_in & a[WIDTH-1];
    assign b_neg  = sgn_in & b[WIDTH-1];
    assign mag_a  = a_neg ? ({(WIDTH+1){1'b0}} - {1'b1, a}) : {1'b0, a};
    assign mag_b  = b_neg ? ({(WIDTH+1){1'b0}} - {1'b1, b}) : {1'b0, b};

    // Per-iteration datapath
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ge;

    assign mul_sum   = {1'b0, rem_q[WIDTH-1:0]} + (quo_q[0] ? mag_b_q : {(WIDTH+1){1'b0}});
    assign div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {1'b0, mag_b_q};
    assign div_ge    = ~div_diff[WIDTH+1];

    // Final sign correction
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_raw = {rem_q[WIDTH-1:0], quo_q};
    assign prod_fix = neg_lo_q ? ({(2*WIDTH){1'b0}} - prod_raw) : prod_raw;
    assign quo_fix  = div0_q ? {WIDTH{1'b1}}
                    : (neg_lo_q ? ({WIDTH{1'b0}} - quo_q) : quo_q);
    assign rem_fix  = neg_hi_q ? ({WIDTH{1'b0}} - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        mag_b_d  = mag_b_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // A coincident move is dropped; cancel suppresses the launch itself.
                    if (!cancel) begin
                        state_d  = StCalc;
                        op_d     = op_in;
                        cnt_d    = '0;
                        rem_d    = '0;
                        quo_d    = mag_a[WIDTH-1:0];
                        mag_b_d  = mag_b;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = md_is_div(op_in) & a_neg;
                        div0_d   = md_is_div(op_in) & (b == '0);
                    end
                end else begin
                    if (mthi) hi_d = a;
                    if (mtlo) lo_d = a;
                end
            end
            StCalc: begin
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    if (md_is_div(op_q)) begin
                        rem_d = div_ge ? div_diff[WIDTH:0] : div_shift;
                        quo_d = {quo_q[WIDTH-2:0], div_ge};
                    end else begin
                        rem_d = {1'b0, mul_sum[WIDTH:1]};
                        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (md_is_div(op_q)) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            op_q     <= OpMult;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            mag_b_q  <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            mag_b_q  <= mag_b_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: arithmetic results, latency, moves, cancel and reset.
module tb_exe_muldiv;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        cancel = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    exe_muldiv #(.WIDTH(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .cancel (cancel),
        .a      (a),
        .b      (b),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clock = ~clock;

    // Launches at the next rising edge (caller sits at a falling edge), scrambles the
    // operand inputs while busy, and records what happens over the following 40 edges.
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          output int done_at, output int pulses, output logic busy_ok,
                          output logic [31:0] hv, output logic [31:0] lv);
        busy_ok = 1'b1;
        done_at = -1;
        pulses  = 0;
        hv      = '0;
        lv      = '0;
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0; a = 32'h5A5A_A5A5; b = 32'h0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (done === 1'b1) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = k;
                    hv = hi;
                    lv = lo;
                    if (busy !== 1'b0) busy_ok = 1'b0;
                end
            end
            if (k <= 32 && busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_arith(input string name, input logic [1:0] o, input logic [31:0] av,
                              input logic [31:0] bv, input logic [31:0] eh,
                              input logic [31:0] el);
        int d, p;
        logic bo;
        logic [31:0] hv, lv;
        run_op(o, av, bv, d, p, bo, hv, lv);
        checks++; if (d !== 33) begin errors++; $display("FAIL %s_latency got=%0d exp=33", name, d); end
        checks++; if (p !== 1) begin errors++; $display("FAIL %s_pulses got=%0d exp=1", name, p); end
        checks++; if (bo !== 1'b1) begin errors++; $display("FAIL %s_busy got=%b exp=1", name, bo); end
        checks++; if (hv !== eh) begin errors++; $display("FAIL %s_hi got=%h exp=%h", name, hv, eh); end
        checks++; if (lv !== el) begin errors++; $display("FAIL %s_lo got=%h exp=%h", name, lv, el); end
    endtask

    task automatic test_cancel;
        int p = 0;
        mthi = 1'b1; a = 32'h1234;
        @(posedge clock); @(negedge clock);
        mthi = 1'b0; mtlo = 1'b1; a = 32'h5678;
        @(posedge clock); @(negedge clock);
        mtlo = 1'b0;
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi got=%h exp=00001234", hi); end
        checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo got=%h exp=00005678", lo); end
        start = 1'b1; op = MULT; a = 32'd3; b = 32'd4;
        @(posedge clock); @(negedge clock);
        start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cancel_pre_busy got=%b exp=1", busy); end
        cancel = 1'b1;
        @(posedge clock); @(negedge clock);
        cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_idle got=%b exp=0", busy); end
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) p++;
            @(negedge clock);
        end
        checks++; if (p !== 0) begin errors++; $display("FAIL cancel_done got=%0d exp=0", p); end
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL cancel_hi got=%h exp=00001234", hi); end
        checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL cancel_lo got=%h exp=00005678", lo); end
    endtask

    task automatic test_start_priority;
        int d = -1;
        logic [31:0] hv = '0, lv = '0;
        mthi = 1'b1; mtlo = 1'b1; a = 32'hAAAA;
        @(posedge clock); @(negedge clock);
        mthi = 1'b0; mtlo = 1'b0;
        start = 1'b1; mthi = 1'b1; op = MULTU; a = 32'd6; b = 32'd7;
        @(posedge clock); @(negedge clock);
        start = 1'b0; mthi = 1'b0;
        checks++; if (hi !== 32'hAAAA) begin errors++; $display("FAIL prio_hi got=%h exp=0000aaaa", hi); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_launch got=%b exp=1", busy); end
        mtlo = 1'b1; a = 32'hDEAD;
        @(posedge clock); @(negedge clock);
        mtlo = 1'b0;
        checks++; if (lo !== 32'hAAAA) begin errors++; $display("FAIL busy_mtlo got=%h exp=0000aaaa", lo); end
        for (int k = 2; k <= 40; k++) begin
            @(posedge clock); @(negedge clock);
            if (done === 1'b1 && d < 0) begin d = k; hv = hi; lv = lo; end
        end
        checks++; if (d !== 33) begin errors++; $display("FAIL prio_latency got=%0d exp=33", d); end
        checks++; if (hv !== 32'h0) begin errors++; $display("FAIL prio_res_hi got=%h exp=0", hv); end
        checks++; if (lv !== 32'd42) begin errors++; $display("FAIL prio_res_lo got=%h exp=0000002a", lv); end
    endtask

    task automatic test_reset_mid_op;
        int d, p;
        logic bo;
        logic [31:0] hv, lv;
        start = 1'b1; op = DIV; a = 32'd100; b = 32'd7;
        @(posedge clock); @(negedge clock);
        start = 1'b0;
        repeat (4) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo got=%h exp=0", lo); end
        @(negedge clock);
        reset = 1'b1;
        test_arith("rst_relaunch", DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);
    endtask

    initial begin
        test_reset;
        test_arith("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        test_arith("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        test_arith("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        test_arith("div_negb", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        test_arith("divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        test_arith("divu_zero", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        test_arith("div_zero", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        test_arith("mult_minneg", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        test_arith("div_minneg", DIV, 32'h8000_0000, 32'd1, 32'h0, 32'h8000_0000);
        test_cancel;
        test_start_priority;
        test_reset_mid_op;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
